// File: rtl/aes_round_ctrl.sv
// Sequencer for the shared AES encryption round datapath: load, then one
// SUB/SHIFT/MIX/ADDKEY op per cycle in round order, stalling ADDKEY on the key schedule.
module aes_round_ctrl #(
  parameter int unsigned NROUNDS = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_valid,
  output logic       start_ready,
  output logic       dp_load,
  output logic       op_valid,
  output logic [1:0] op,
  output logic [3:0] round_idx,
  output logic       key_req,
  input  logic       key_valid,
  output logic       done_valid,
  input  logic       done_ready,
  output logic       busy
);

  localparam int unsigned RW  = 4;
  localparam int unsigned OPW = 2;

  localparam logic [OPW-1:0] OP_SUB    = OPW'(0);
  localparam logic [OPW-1:0] OP_SHIFT  = OPW'(1);
  localparam logic [OPW-1:0] OP_MIX    = OPW'(2);
  localparam logic [OPW-1:0] OP_ADDKEY = OPW'(3);

  localparam logic [RW-1:0] LAST_ROUND = RW'(NROUNDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [RW-1:0]  round_q, round_d;
  logic [OPW-1:0] step_q, step_d;
  logic           op_fire;

  logic start_ready_d, busy_d, dp_load_d, done_valid_d, key_req_d;

  // State, round/step counters and registered status outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      round_q     <= '0;
      step_q      <= OP_ADDKEY;
      start_ready <= 1'b1;
      busy        <= 1'b0;
      dp_load     <= 1'b0;
      done_valid  <= 1'b0;
      key_req     <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      step_q      <= step_d;
      start_ready <= start_ready_d;
      busy        <= busy_d;
      dp_load     <= dp_load_d;
      done_valid  <= done_valid_d;
      key_req     <= key_req_d;
    end
  end

  // Next-state and step sequencing; ADDKEY only advances when the key is present
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    step_d  = step_q;
    op_fire = (state_q == RUN) && ((step_q != OP_ADDKEY) || key_valid);

    unique case (state_q)
      IDLE: begin
        if (start_valid && start_ready) state_d = LOAD;
      end
      LOAD: begin
        state_d = RUN;
        round_d = '0;
        step_d  = OP_ADDKEY;
      end
      RUN: begin
        if (op_fire) begin
          unique case (step_q)
            OP_SUB:   step_d = OP_SHIFT;
            // the final round has no MixColumns
            OP_SHIFT: step_d = (round_q == LAST_ROUND) ? OP_ADDKEY : OP_MIX;
            OP_MIX:   step_d = OP_ADDKEY;
            OP_ADDKEY: begin
              if (round_q == LAST_ROUND) begin
                state_d = DONE;
              end else begin
                round_d = round_q + RW'(1);
                step_d  = OP_SUB;
              end
            end
            default: step_d = step_q;
          endcase
        end
      end
      DONE: begin
        if (done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    start_ready_d = (state_d == IDLE);
    busy_d        = (state_d != IDLE);
    dp_load_d     = (state_d == LOAD);
    done_valid_d  = (state_d == DONE);
    key_req_d     = (state_d == RUN) && (step_d == OP_ADDKEY);
  end

  assign op_valid  = op_fire;
  assign op        = step_q;
  assign round_idx = round_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl: expected op/round sequence queued at start
// acceptance, popped as the controller issues ops; NROUNDS 10 and 14 instances.
module tb_aes_round_ctrl;

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] rnd;
  } exp_t;

  localparam logic [1:0] OP_SUB = 2'd0, OP_SHIFT = 2'd1, OP_MIX = 2'd2, OP_ADDKEY = 2'd3;

  logic clk, reset_n, key_valid, done_ready;
  logic sv10, sr10, dl10, ov10, kr10, dv10, bz10;
  logic sv14, sr14, dl14, ov14, kr14, dv14, bz14;
  logic [1:0] op10, op14;
  logic [3:0] ri10, ri14;

  aes_round_ctrl #(.NROUNDS(10)) dut10 (
    .clk(clk), .reset_n(reset_n), .start_valid(sv10), .start_ready(sr10),
    .dp_load(dl10), .op_valid(ov10), .op(op10), .round_idx(ri10), .key_req(kr10),
    .key_valid(key_valid), .done_valid(dv10), .done_ready(done_ready), .busy(bz10)
  );

  aes_round_ctrl #(.NROUNDS(14)) dut14 (
    .clk(clk), .reset_n(reset_n), .start_valid(sv14), .start_ready(sr14),
    .dp_load(dl14), .op_valid(ov14), .op(op14), .round_idx(ri14), .key_req(kr14),
    .key_valid(key_valid), .done_valid(dv14), .done_ready(done_ready), .busy(bz14)
  );

  logic sel;
  logic o_start_ready, o_dp_load, o_op_valid, o_key_req, o_done_valid, o_busy;
  logic [1:0] o_op;
  logic [3:0] o_round_idx;

  assign o_start_ready = sel ? sr14 : sr10;
  assign o_dp_load     = sel ? dl14 : dl10;
  assign o_op_valid    = sel ? ov14 : ov10;
  assign o_key_req     = sel ? kr14 : kr10;
  assign o_done_valid  = sel ? dv14 : dv10;
  assign o_busy        = sel ? bz14 : bz10;
  assign o_op          = sel ? op14 : op10;
  assign o_round_idx   = sel ? ri14 : ri10;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // bench-side expectation state
  exp_t exp_q[$];
  logic mon_en, rst_drv, sv_cur, kv_cur, dr_cur;
  logic exp_ready, in_block, done_seen, dv_seen;
  int cyc, t0, exp_lat, exp_hold;
  int op_cnt, mix_cnt, mix_last, max_rnd, done_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int n_cur();
    return sel ? 14 : 10;
  endfunction

  function automatic exp_t mk(input logic [1:0] o, input int r);
    exp_t e;
    e.op  = o;
    e.rnd = 4'(r);
    return e;
  endfunction

  task automatic push_block(input int n);
    exp_q.push_back(mk(OP_ADDKEY, 0));
    for (int r = 1; r < n; r++) begin
      exp_q.push_back(mk(OP_SUB, r));
      exp_q.push_back(mk(OP_SHIFT, r));
      exp_q.push_back(mk(OP_MIX, r));
      exp_q.push_back(mk(OP_ADDKEY, r));
    end
    exp_q.push_back(mk(OP_SUB, n));
    exp_q.push_back(mk(OP_SHIFT, n));
    exp_q.push_back(mk(OP_ADDKEY, n));
  endtask

  task automatic monitor();
    logic in_run, exp_kr, exp_opv, exp_done;
    exp_t e;
    if (!mon_en) return;
    check("start_ready", 32'(o_start_ready), 32'(exp_ready));
    check("busy", 32'(o_busy), 32'(!exp_ready));
    if (sv_cur && exp_ready) begin
      exp_ready = 1'b0;
      in_block  = 1'b1;
      done_seen = 1'b0;
      dv_seen   = 1'b0;
      t0        = cyc;
      exp_lat   = 4 * n_cur() + 2;
      op_cnt = 0; mix_cnt = 0; mix_last = 0; max_rnd = 0; done_cnt = 0;
      exp_q.delete();
      push_block(n_cur());
    end
    in_run  = in_block && (cyc >= t0 + 2) && (cyc < t0 + exp_lat);
    exp_kr  = in_run && (exp_q.size() > 0) && (exp_q[0].op == OP_ADDKEY);
    exp_opv = in_run && (kv_cur || !exp_kr);
    check("dp_load", 32'(o_dp_load), 32'(in_block && (cyc == t0 + 1)));
    check("key_req", 32'(o_key_req), 32'(exp_kr));
    check("op_valid", 32'(o_op_valid), 32'(exp_opv));
    if (exp_kr && !kv_cur) check("stall_round", 32'(o_round_idx), 32'(exp_q[0].rnd));
    if (o_op_valid) begin
      if (exp_q.size() == 0) begin
        check("op_extra", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("op", 32'(o_op), 32'(e.op));
        check("round_idx", 32'(o_round_idx), 32'(e.rnd));
        op_cnt++;
        if (o_op == OP_MIX) mix_cnt++;
        if (o_op == OP_MIX && o_round_idx == 4'(n_cur())) mix_last++;
        if (int'(o_round_idx) > max_rnd) max_rnd = int'(o_round_idx);
      end
    end
    exp_done = in_block && (cyc >= t0 + exp_lat);
    check("done_valid", 32'(o_done_valid), 32'(exp_done));
    if (o_done_valid) begin
      done_cnt++;
      if (!dv_seen && in_block) check("done_cycle", 32'(cyc - t0), 32'(exp_lat));
      dv_seen = 1'b1;
    end
    if (exp_done) done_seen = 1'b1;
    if (exp_done && dr_cur) begin
      check("ops_left", 32'(exp_q.size()), 32'(0));
      check("op_count", 32'(op_cnt), 32'(4 * n_cur()));
      check("mix_count", 32'(mix_cnt), 32'(n_cur() - 1));
      check("mix_final_round", 32'(mix_last), 32'(0));
      check("max_round", 32'(max_rnd), 32'(n_cur()));
      check("done_hold", 32'(done_cnt), 32'(exp_hold));
      in_block  = 1'b0;
      exp_ready = 1'b1;
    end
    if (!reset_n) begin
      exp_q.delete();
      in_block  = 1'b0;
      exp_ready = 1'b1;
    end
  endtask

  task automatic step(input logic sv, input logic kv, input logic dr);
    @(posedge clk);
    #1;
    cyc++;
    sv10 = sel ? 1'b0 : sv;
    sv14 = sel ? sv : 1'b0;
    key_valid = kv;
    done_ready = dr;
    reset_n = rst_drv;
    sv_cur = sv; kv_cur = kv; dr_cur = dr;
    @(negedge clk);
    monitor();
  endtask

  // one block: optional key_valid-low window at relative cycles, extra expected latency,
  // done_ready hold-off cycles, and start_valid pokes while busy
  task automatic run_block(input int kv_lo_rel, input int kv_lo_n, input int extra,
                           input int hold, input logic poke);
    int guard;
    int rel;
    logic kvv;
    exp_hold = hold + 1;
    step(1'b1, 1'b1, 1'b1);
    exp_lat += extra;
    guard = 0;
    while (in_block && !done_seen && guard < 300) begin
      rel = cyc + 1 - t0;
      kvv = !(rel >= kv_lo_rel && rel < kv_lo_rel + kv_lo_n);
      step(poke, kvv, 1'(hold == 0));
      guard++;
    end
    if (!done_seen) check("done_timeout", 32'(0), 32'(1));
    for (int i = 1; i < hold; i++) step(poke, 1'b1, 1'b0);
    if (hold > 0) step(1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    sel = 1'b0; mon_en = 1'b0; rst_drv = 1'b0;
    reset_n = 1'b0; sv10 = 1'b0; sv14 = 1'b0; key_valid = 1'b1; done_ready = 1'b1;
    sv_cur = 1'b0; kv_cur = 1'b1; dr_cur = 1'b1;
    exp_ready = 1'b1; in_block = 1'b0; done_seen = 1'b0; dv_seen = 1'b0;
    cyc = 0; t0 = 0; exp_lat = 0; exp_hold = 1;
    op_cnt = 0; mix_cnt = 0; mix_last = 0; max_rnd = 0; done_cnt = 0;
    repeat (3) step(1'b0, 1'b1, 1'b1);
    rst_drv = 1'b1;
    mon_en = 1'b1;

    // idle after reset
    repeat (5) begin
      step(1'b0, 1'b1, 1'b1);
      check("idle_round", 32'(o_round_idx), 32'(0));
    end

    // plain block, then round-5 ADDKEY stalled 3 cycles
    run_block(0, 0, 0, 0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    run_block(22, 3, 3, 0, 1'b0);

    // done_ready held off 4 cycles with start_valid pokes while busy, then next block
    run_block(0, 0, 0, 4, 1'b1);
    run_block(0, 0, 0, 0, 1'b0);
    step(1'b0, 1'b1, 1'b1);

    // reset during round 3 SHIFT
    exp_hold = 1;
    step(1'b1, 1'b1, 1'b1);
    for (int k = 1; k < 12; k++) step(1'b0, 1'b1, 1'b1);
    rst_drv = 1'b0;
    step(1'b0, 1'b1, 1'b1);
    check("rst_at_op", 32'(o_op), 32'(OP_SHIFT));
    check("rst_at_round", 32'(o_round_idx), 32'(3));
    rst_drv = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    check("rst_start_ready", 32'(o_start_ready), 32'(1));
    check("rst_busy", 32'(o_busy), 32'(0));
    check("rst_op_valid", 32'(o_op_valid), 32'(0));
    check("rst_dp_load", 32'(o_dp_load), 32'(0));
    check("rst_key_req", 32'(o_key_req), 32'(0));
    check("rst_done_valid", 32'(o_done_valid), 32'(0));
    check("rst_round_idx", 32'(o_round_idx), 32'(0));
    run_block(0, 0, 0, 0, 1'b0);
    step(1'b0, 1'b1, 1'b1);

    // NROUNDS=14, key_valid low on round-1 SUB/SHIFT/MIX (must not stall)
    sel = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    run_block(3, 3, 0, 0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Sequences the shared AES encryption round datapath: matrixify → SubBytes/ShiftRows/MixColumns/AddRoundKey → dematrixify.
- Accepts one block per start handshake and tells the datapath when to load the state matrix.
- Issues one datapath operation per cycle, in AES round order, and stalls each AddRoundKey until the key schedule presents that round's key.
- Raises done_valid when the state register holds ciphertext; dematrixify then produces the 128-bit rawstring.

Parameters:
- NROUNDS, 10, number of full AES rounds. Legal values are 10, 12 and 14; any other value is unsupported.

Ports:
- clk  input  1  single system clock; all logic is on the rising edge.
- reset_n  input  1  reset, synchronous, active-low.
- start_valid  input  1  requester has a block ready in the matrixify input register.
- start_ready  output  1  controller can accept a block (high only in IDLE).
- dp_load  output  1  one-cycle strobe: datapath loads the state matrix from matrixify.
- op_valid  output  1  datapath applies op to the state this cycle.
- op  output  2  operation code: 0=SUB, 1=SHIFT, 2=MIX, 3=ADDKEY.
- round_idx  output  4  current round, 0..NROUNDS; also the key index requested.
- key_req  output  1  high while waiting on, or consuming, the ADDKEY key.
- key_valid  input  1  key schedule presents the round key for round_idx.
- done_valid  output  1  state register holds the ciphertext.
- done_ready  input  1  consumer has taken the result (dematrixify output).
- busy  output  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, LOAD, RUN, DONE.
- Internal registers: round_idx (4 bits) and step (2 bits, same encoding as op).
- Reset: when reset_n is sampled low at a clock edge, go to IDLE and clear all registers:
  - round_idx=0, step=ADDKEY;
  - dp_load=0, op_valid=0, key_req=0, done_valid=0, busy=0;
  - start_ready=1 from the first cycle after reset.
- Reset mid-operation aborts the block with no done_valid. The datapath state contents are don't-care.
- IDLE:
  - start_ready=1.
  - When start_valid&&start_ready, go to LOAD.
- LOAD:
  - dp_load=1 for exactly one cycle.
  - Next state RUN with round_idx=0, step=ADDKEY.
- RUN:
  - op = step.
  - key_req = (step==ADDKEY).
  - For SUB/SHIFT/MIX, op_valid=1 unconditionally.
  - For ADDKEY, op_valid=key_valid. If key_valid=0, hold all state (stall) with no limit.
- Step advance, only on cycles where op_valid=1:
  - round 0: ADDKEY → round 1, SUB.
  - rounds 1..NROUNDS-1: SUB → SHIFT → MIX → ADDKEY → next round, SUB.
  - round NROUNDS: SUB → SHIFT → ADDKEY. MIX is skipped; op=2 never appears in the final round.
  - ADDKEY in round NROUNDS → DONE.
- DONE:
  - done_valid=1; outputs are held until done_valid&&done_ready, then IDLE.
  - start_ready becomes 1 in the cycle after the DONE handshake, never the same cycle.
- Latency with key_valid tied high (cycle 0 = start handshake):
  - dp_load in cycle 1;
  - ops in cycles 2..4*NROUNDS+1 (4*NROUNDS ops total);
  - done_valid first high in cycle 4*NROUNDS+2, which is 42 for NROUNDS=10.
  - Each stalled ADDKEY cycle adds exactly one cycle.
- start_valid while busy is ignored (start_ready=0). It is not queued.
- key_valid outside ADDKEY steps is ignored.
- round_idx never exceeds NROUNDS and does not wrap.
- op_valid and dp_load are never high in the same cycle.

Test Plan:
- Reset, then idle → start_ready=1, busy=0, op_valid=0, done_valid=0; hold 5 cycles, outputs unchanged.
- NROUNDS=10, key_valid=1, start pulse at cycle 0 →
  - dp_load at cycle 1;
  - cycle 2: op=3, round_idx=0;
  - cycles 3..6: op=0,1,2,3, round_idx=1;
  - cycles 39..41: op=0,1,3, round_idx=10;
  - done_valid at cycle 42;
  - total op_valid count 40, MIX count 9.
- key_valid low for 3 cycles at round 5 ADDKEY → op_valid=0, key_req=1, round_idx=5 held for 3 cycles; done_valid at cycle 45.
- done_ready low for 4 cycles, and start_valid asserted during RUN → done_valid held high 5 cycles, start_ready=0 throughout; accept in IDLE, next block completes normally.
- reset_n low for 1 cycle at round 3, SHIFT → next cycle IDLE, all outputs at reset values, no done_valid; a new start runs a full 42-cycle sequence.
- NROUNDS=14 → done_valid at cycle 58, final round has no op=2, round_idx max 14.
